gat_stage_scheduler: RTL and testbench

GAT_STAGE_SCHEDULER -- requirements
Module: gat_stage_scheduler

---
 rtl/gat_stage_scheduler.sv | 131 +++++++++++++
 tb/tb_gat_stage_scheduler.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/gat_stage_scheduler.sv
// Four-stage GAT batch scheduler: pushes subgraphs through spmm -> dmvm -> sm -> aggr,
// one outstanding subgraph per stage, with batch completion, cycle count and sticky error.
module gat_stage_scheduler #(
  parameter int SG_W = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start_i,
  input  logic [SG_W-1:0] num_sg_i,
  input  logic            clr_i,
  input  logic            spmm_rdy_i,
  input  logic            dmvm_rdy_i,
  input  logic            sm_rdy_i,
  input  logic            aggr_rdy_i,
  input  logic            spmm_vld_i,
  input  logic            dmvm_vld_i,
  input  logic            sm_vld_i,
  input  logic            aggr_vld_i,
  output logic            spmm_start_o,
  output logic            dmvm_start_o,
  output logic            sm_start_o,
  output logic            aggr_start_o,
  output logic            busy_o,
  output logic            done_o,
  output logic            err_o,
  output logic [31:0]     cycle_cnt_o,
  output logic [SG_W-1:0] sg_done_cnt_o
);
  localparam int NSTG = 4;

  typedef enum logic {IDLE, RUN} state_e;

  state_e                     state_q;
  logic [SG_W-1:0]            num_sg_q;
  logic                       done_q, err_q;
  logic [31:0]                cyc_q;
  logic [NSTG-1:0]            rdy, vld, fire, ack, start;
  logic [NSTG-1:0][SG_W-1:0]  dn, lim;
  logic                       run, accept, stg_clr, fin;

  assign rdy     = {aggr_rdy_i, sm_rdy_i, dmvm_rdy_i, spmm_rdy_i};
  assign vld     = {aggr_vld_i, sm_vld_i, dmvm_vld_i, spmm_vld_i};
  assign run     = (state_q == RUN);
  assign accept  = !run && start_i && (num_sg_i != '0);
  assign stg_clr = clr_i || accept;
  // Stage 0 is bounded by the batch size, every later stage by its predecessor's completions.
  assign lim     = {dn[NSTG-2:0], num_sg_q};
  assign fin     = ack[NSTG-1] && ((dn[NSTG-1] + SG_W'(1)) == num_sg_q);

  for (genvar k = 0; k < NSTG; k++) begin : g_stg
    logic [SG_W-1:0] iss_q, dn_q;
    logic            bsy_q, start_q;

    assign fire[k]  = run && !bsy_q && rdy[k] && (iss_q < lim[k]);
    assign ack[k]   = run && vld[k] && bsy_q;
    assign dn[k]    = dn_q;
    assign start[k] = start_q;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        iss_q   <= '0;
        dn_q    <= '0;
        bsy_q   <= 1'b0;
        start_q <= 1'b0;
      end else if (stg_clr) begin
        iss_q   <= '0;
        dn_q    <= '0;
        bsy_q   <= 1'b0;
        start_q <= 1'b0;
      end else begin
        start_q <= fire[k];
        // fire needs bsy=0 and ack needs bsy=1, so they never coincide
        if (fire[k]) begin
          iss_q <= iss_q + SG_W'(1);
          bsy_q <= 1'b1;
        end else if (ack[k]) begin
          dn_q  <= dn_q + SG_W'(1);
          bsy_q <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      num_sg_q <= '0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      cyc_q    <= '0;
    end else if (clr_i) begin
      state_q  <= IDLE;
      num_sg_q <= '0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      cyc_q    <= '0;
    end else begin
      done_q <= 1'b0;
      // any completion pulse that no busy stage can absorb is a protocol error
      if (|(vld & ~ack)) err_q <= 1'b1;
      case (state_q)
        IDLE: if (start_i) begin
          if (num_sg_i == '0) done_q <= 1'b1;
          else begin
            state_q  <= RUN;
            num_sg_q <= num_sg_i;
            cyc_q    <= '0;
          end
        end
        RUN: begin
          if (cyc_q != '1) cyc_q <= cyc_q + 32'd1;
          if (fin) begin
            state_q <= IDLE;
            done_q  <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign spmm_start_o  = start[0];
  assign dmvm_start_o  = start[1];
  assign sm_start_o    = start[2];
  assign aggr_start_o  = start[3];
  assign busy_o        = run;
  assign done_o        = done_q;
  assign err_o         = err_q;
  assign cycle_cnt_o   = cyc_q;
  assign sg_done_cnt_o = dn[NSTG-1];
endmodule

// File: tb/tb_gat_stage_scheduler.sv
// Scoreboard bench for gat_stage_scheduler: stage responders echo start pulses back as vld,
// a cycle model of the scheduling rules is checked every cycle, batch results pop off a queue.
module tb_gat_stage_scheduler;
  localparam int SG_W   = 16;
  localparam int BUDGET = 2000;

  logic clk = 1'b0;
  logic rst_n, start_i, clr_i;
  logic [SG_W-1:0] num_sg_i;
  logic [3:0] rdy, resp_vld, inj_vld, vld, start_v;
  logic spmm_start_o, dmvm_start_o, sm_start_o, aggr_start_o;
  logic busy_o, done_o, err_o;
  logic [31:0] cycle_cnt_o;
  logic [SG_W-1:0] sg_done_cnt_o;

  int errs = 0, checks = 0;
  int fixed_dly = 0;
  int exp_q[$];
  int ndone = 0;

  // reference model state
  bit          mrun, merr;
  int          mnum;
  int          mdn[4], miss[4], obs[4];
  logic [3:0]  mbusy;
  logic [31:0] mcyc;

  always #5 clk = ~clk;

  assign vld     = resp_vld | inj_vld;
  assign start_v = {aggr_start_o, sm_start_o, dmvm_start_o, spmm_start_o};

  gat_stage_scheduler #(.SG_W(SG_W)) dut (
    .clk(clk), .rst_n(rst_n), .start_i(start_i), .num_sg_i(num_sg_i), .clr_i(clr_i),
    .spmm_rdy_i(rdy[0]), .dmvm_rdy_i(rdy[1]), .sm_rdy_i(rdy[2]), .aggr_rdy_i(rdy[3]),
    .spmm_vld_i(vld[0]), .dmvm_vld_i(vld[1]), .sm_vld_i(vld[2]), .aggr_vld_i(vld[3]),
    .spmm_start_o(spmm_start_o), .dmvm_start_o(dmvm_start_o),
    .sm_start_o(sm_start_o), .aggr_start_o(aggr_start_o),
    .busy_o(busy_o), .done_o(done_o), .err_o(err_o),
    .cycle_cnt_o(cycle_cnt_o), .sg_done_cnt_o(sg_done_cnt_o)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    for (int k = 0; k < 4; k++) begin
      mdn[k] = 0; miss[k] = 0; obs[k] = 0;
    end
    mbusy = '0;
  endtask

  // stage responders: each start comes back as a vld pulse d cycles later
  initial begin
    int cnt[4];
    int d;
    resp_vld = '0;
    for (int k = 0; k < 4; k++) cnt[k] = 0;
    forever begin
      @(negedge clk);
      for (int k = 0; k < 4; k++) begin
        resp_vld[k] = 1'b0;
        if (cnt[k] > 0) begin
          cnt[k]--;
          if (cnt[k] == 0) resp_vld[k] = 1'b1;
        end
        if (start_v[k]) begin
          d = (fixed_dly > 0) ? fixed_dly : int'($urandom_range(1, 4));
          if (d == 1) resp_vld[k] = 1'b1;
          else cnt[k] = d - 1;
        end
      end
    end
  end

  // monitor: inputs are held across the edge, so at posedge+1 they show what was sampled
  initial begin
    logic [3:0] es, vb;
    int lim, e;
    bit md;
    mrun = 0; merr = 0; mnum = 0; mcyc = '0;
    model_clear();
    forever begin
      @(posedge clk); #1;
      if (!rst_n) begin
        check("rst_ctl", {25'd0, busy_o, done_o, err_o, start_v}, 32'd0);
        check("rst_cyc", cycle_cnt_o, 32'd0);
        check("rst_sg", 32'(sg_done_cnt_o), 32'd0);
        mrun = 0; merr = 0; mcyc = '0;
        model_clear();
        exp_q.delete();
      end else begin
        md = 0;
        es = '0;
        if (clr_i) begin
          mrun = 0; merr = 0; mcyc = '0;
          model_clear();
          exp_q.delete();
        end else begin
          for (int k = 0; k < 4; k++) begin
            if (k == 0) lim = mnum;
            else lim = mdn[k-1];
            if (mrun && !mbusy[k] && rdy[k] && miss[k] < lim) es[k] = 1'b1;
            if (vld[k] && !(mrun && mbusy[k])) merr = 1;
          end
          vb = vld & mbusy & {4{mrun}};
          for (int k = 0; k < 4; k++) begin
            if (vb[k]) begin mdn[k]++; mbusy[k] = 1'b0; end
            if (es[k]) begin miss[k]++; mbusy[k] = 1'b1; end
          end
          if (mrun) begin
            if (mcyc != 32'hFFFF_FFFF) mcyc = mcyc + 32'd1;
            if (vb[3] && mdn[3] == mnum) begin mrun = 0; md = 1; end
          end else if (start_i) begin
            if (num_sg_i == '0) md = 1;
            else begin
              mrun = 1; mnum = int'(num_sg_i); mcyc = '0;
              model_clear();
            end
          end
        end
        for (int k = 0; k < 4; k++) check($sformatf("start_%0d", k), 32'(start_v[k]), 32'(es[k]));
        check("busy", 32'(busy_o), 32'(mrun));
        check("done", 32'(done_o), 32'(md));
        check("err", 32'(err_o), 32'(merr));
        check("cycle_cnt", cycle_cnt_o, mcyc);
        check("sg_done_cnt", 32'(sg_done_cnt_o), 32'(mdn[3]));
        for (int k = 0; k < 4; k++) if (start_v[k]) obs[k]++;
        if (done_o) begin
          ndone++;
          check("done_expected", 32'(exp_q.size() > 0), 32'd1);
          if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            if (e > 0) begin
              check("sb_sg_done", 32'(sg_done_cnt_o), 32'(e));
              for (int k = 0; k < 4; k++) check($sformatf("sb_starts_%0d", k), 32'(obs[k]), 32'(e));
            end
          end
        end
      end
    end
  end

  task automatic start_batch(input int num);
    exp_q.push_back(num);
    @(negedge clk); start_i = 1'b1; num_sg_i = SG_W'(num);
    @(negedge clk); start_i = 1'b0;
  endtask

  task automatic wait_done(input bit rnd);
    int n = 0;
    while (exp_q.size() != 0 && n < BUDGET) begin
      if (rnd) begin
        rdy = 4'($urandom) | 4'($urandom);
        if (busy_o && $urandom_range(0, 15) == 0) begin
          start_i = 1'b1; num_sg_i = SG_W'($urandom);
        end
      end
      @(negedge clk); start_i = 1'b0; n++;
    end
    rdy = 4'hF;
    check("batch_complete", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic pulse_clr();
    @(negedge clk); clr_i = 1'b1;
    @(negedge clk); clr_i = 1'b0;
  endtask

  initial begin
    int sv, n;
    rst_n = 1'b0; start_i = 1'b0; clr_i = 1'b0; num_sg_i = '0;
    rdy = 4'hF; inj_vld = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // one subgraph, 3-cycle stage latency
    fixed_dly = 3;
    start_batch(1);
    wait_done(0);
    check("s1_err", 32'(err_o), 32'd0);
    check("s1_sg", 32'(sg_done_cnt_o), 32'd1);

    // empty batch
    sv = ndone;
    exp_q.push_back(0);
    @(negedge clk); start_i = 1'b1; num_sg_i = '0;
    @(posedge clk); #1;
    check("z_done", 32'(done_o), 32'd1);
    check("z_busy", 32'(busy_o), 32'd0);
    @(negedge clk); start_i = 1'b0;
    @(posedge clk); #1;
    check("z_busy2", 32'(busy_o), 32'd0);
    check("z_done_once", 32'(ndone - sv), 32'd1);

    // aggr stalled for 50 cycles
    rdy = 4'b0111;
    sv = ndone;
    start_batch(4);
    repeat (50) @(negedge clk);
    check("stall_spmm", 32'(obs[0]), 32'd4);
    check("stall_aggr", 32'(obs[3]), 32'd0);
    rdy = 4'hF;
    wait_done(0);
    check("stall_done_once", 32'(ndone - sv), 32'd1);

    // stray dmvm completion while idle
    @(negedge clk); inj_vld = 4'b0010;
    @(negedge clk); inj_vld = '0;
    check("err_set", 32'(err_o), 32'd1);
    check("err_sg", 32'(sg_done_cnt_o), 32'd4);
    repeat (5) @(negedge clk);
    check("err_sticky", 32'(err_o), 32'd1);
    pulse_clr();
    check("err_clr", 32'(err_o), 32'd0);

    // abort a batch of 8 once 3 subgraphs are through
    fixed_dly = 0;
    sv = ndone;
    start_batch(8);
    n = 0;
    while (sg_done_cnt_o < 3 && n < BUDGET) begin @(negedge clk); n++; end
    check("clr_reach3", 32'(n < BUDGET), 32'd1);
    clr_i = 1'b1;
    @(posedge clk); #1;
    check("clr_busy", 32'(busy_o), 32'd0);
    check("clr_sg", 32'(sg_done_cnt_o), 32'd0);
    check("clr_cyc", cycle_cnt_o, 32'd0);
    check("clr_done", 32'(done_o), 32'd0);
    @(negedge clk); clr_i = 1'b0;
    repeat (10) @(negedge clk);
    check("clr_no_done", 32'(ndone - sv), 32'd0);
    pulse_clr();

    // randomized batches with back-pressure and ignored restarts
    for (int b = 0; b < 6; b++) begin
      start_batch(int'($urandom_range(1, 6)));
      wait_done(1);
      check("rnd_err", 32'(err_o), 32'd0);
    end

    // reset in the middle of a batch
    sv = ndone;
    start_batch(5);
    repeat (8) @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    check("rst_no_done", 32'(ndone - sv), 32'd0);
    check("rst_busy", 32'(busy_o), 32'd0);
    pulse_clr();

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
